board_io_ctrl: RTL

Parametrised board I/O front end between a board top level and the example logic.
- Synchronises and debounces N buttons and M switches.
- Generates one-cycle press/release pulses per button.
- Drives K RGB LEDs with per-channel PWM brightness, with duty updates only at period boundaries.
- Replaces direct wiring of raw buttons, switches and LEDs into examples.

---
 rtl/board_io_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O front end: synchronise/debounce buttons and switches, press/release pulses, RGB PWM.
// Optional BOARD_IO_LONG_PRESS_EN adds long-press pulses; all outputs registered, no backpressure.
module board_io_ctrl #(
    parameter int NUM_BUTTONS       = 4,
    parameter int NUM_SWITCHES      = 4,
    parameter int NUM_RGB           = 4,
    parameter int PWM_BITS          = 8,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NUM_BUTTONS-1:0]           buttons_i,
    input  logic [NUM_SWITCHES-1:0]          switches_i,
    output logic [NUM_BUTTONS-1:0]           btn_level_o,
    output logic [NUM_BUTTONS-1:0]           btn_press_o,
    output logic [NUM_BUTTONS-1:0]           btn_release_o,
    output logic [NUM_BUTTONS-1:0]           btn_long_o,
    output logic [NUM_SWITCHES-1:0]          sw_level_o,
    input  logic                             pwm_en_i,
    input  logic [NUM_RGB*3*PWM_BITS-1:0]    rgb_duty_i,
    output logic [NUM_RGB*3-1:0]             rgb_leds_o
);

    localparam int NUM_IN = NUM_BUTTONS + NUM_SWITCHES;
    localparam int NUM_CH = NUM_RGB * 3;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
        $error("board_io_ctrl: SYNC_STAGES, DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
    end

    // Buttons occupy the low bits, switches the high bits of one shared input vector.
    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] w_synced;
    logic [NUM_IN-1:0] r_sync [SYNC_STAGES];

    assign w_raw    = {switches_i, buttons_i};
    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    logic [DB_W-1:0]        r_db_cnt [NUM_IN];
    logic [NUM_IN-1:0]      r_level;
    logic [NUM_IN-1:0]      w_diff;
    logic [NUM_IN-1:0]      w_toggle;
    logic [NUM_BUTTONS-1:0] r_press;
    logic [NUM_BUTTONS-1:0] r_release;

    always_comb begin
        w_diff   = w_synced ^ r_level;
        w_toggle = '0;
        for (int i = 0; i < NUM_IN; i++) w_toggle[i] = w_diff[i] && (r_db_cnt[i] == DB_LAST);
    end

    // Pulses are registered alongside the level so they share its first cycle.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NUM_IN; i++) r_db_cnt[i] <= '0;
        end else begin
            r_level   <= r_level ^ w_toggle;
            r_press   <= w_toggle[NUM_BUTTONS-1:0] & ~r_level[NUM_BUTTONS-1:0];
            r_release <= w_toggle[NUM_BUTTONS-1:0] &  r_level[NUM_BUTTONS-1:0];
            for (int i = 0; i < NUM_IN; i++)
                r_db_cnt[i] <= (w_diff[i] && !w_toggle[i]) ? r_db_cnt[i] + DB_W'(1) : '0;
        end
    end

    assign btn_level_o   = r_level[NUM_BUTTONS-1:0];
    assign sw_level_o    = r_level[NUM_IN-1:NUM_BUTTONS];
    assign btn_press_o   = r_press;
    assign btn_release_o = r_release;

`ifdef BOARD_IO_LONG_PRESS_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [LP_W-1:0]        r_lp_cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] r_long;

    // Saturating one past the fire value guarantees a single pulse per press.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_long <= '0;
            for (int b = 0; b < NUM_BUTTONS; b++) r_lp_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                r_long[b] <= r_level[b] && (r_lp_cnt[b] == LP_FIRE);
                if (!r_level[b])
                    r_lp_cnt[b] <= '0;
                else if (r_lp_cnt[b] != LP_SAT)
                    r_lp_cnt[b] <= r_lp_cnt[b] + LP_W'(1);
            end
        end
    end

    assign btn_long_o = r_long;
`else
    assign btn_long_o = '0;
`endif

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] w_cnt_nxt;
    logic                r_en_d;
    logic                w_load;
    logic [PWM_BITS-1:0] r_shadow     [NUM_CH];
    logic [PWM_BITS-1:0] w_shadow_nxt [NUM_CH];
    logic [NUM_CH-1:0]   r_leds;

    // Duties are captured only at a period boundary or on the first enabled edge.
    always_comb begin
        w_cnt_nxt = pwm_en_i ? r_pwm_cnt + PWM_BITS'(1) : '0;
        w_load    = pwm_en_i && (!r_en_d || (r_pwm_cnt == PWM_LAST));
        for (int c = 0; c < NUM_CH; c++)
            w_shadow_nxt[c] = w_load ? rgb_duty_i[c*PWM_BITS +: PWM_BITS] : r_shadow[c];
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_pwm_cnt <= '0;
            r_en_d    <= 1'b0;
            r_leds    <= '0;
            for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
        end else begin
            r_pwm_cnt <= w_cnt_nxt;
            r_en_d    <= pwm_en_i;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= w_shadow_nxt[c];
                r_leds[c]   <= pwm_en_i && (w_cnt_nxt < w_shadow_nxt[c]);
            end
        end
    end

    assign rgb_leds_o = r_leds;

endmodule
